instruction_fetch: RTL and testbench

Fetch stage of the 16-bit core, directly upstream of the control unit. It owns the program counter and issues word reads to instruction memory over a REQ/ACK handshake. It presents each fetched word on `EXEC` with a valid flag, honours a downstream stall through a one-entry skid register, and redirects on taken branches. Optional halt detection stops fetching when a HLT word is fetched.

---
 rtl/instruction_fetch.sv | 133 +++++++++++++
 tb/tb_instruction_fetch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: PC + REQ/ACK imem reads, EXEC loads one edge after ACK, STALL absorbed by a one-entry skid (HOLD issues no request).
// Define IF_HALT_DETECT_EN to stop fetching once a HLT word (bits[15:14]=11, bits[7:4]=1111) reaches EXEC.
module instruction_fetch #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLOCK,
    input  logic              RESET,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_ACK,
    input  logic [15:0]       IMEM_RDATA,
    input  logic              STALL,
    input  logic              BR_TAKEN,
    input  logic [ADDR_W-1:0] BR_TARGET,
    output logic [15:0]       EXEC,
    output logic              EXEC_VALID,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic              HALTED
);

`ifdef IF_HALT_DETECT_EN
    typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
`endif

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       exec_q;
    logic              exec_vld_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic [15:0]       skid_q;
    logic [ADDR_W-1:0] skid_pc_q;

    logic consumed;
    logic slot_free;
    logic br_take;

    assign consumed  = exec_vld_q && !STALL;
    assign slot_free = !exec_vld_q || !STALL;

`ifdef IF_HALT_DETECT_EN
    logic halted_q;
    logic hlt_mem;
    logic hlt_skid;
    assign hlt_mem  = (IMEM_RDATA[15:14] == 2'b11) && (IMEM_RDATA[7:4] == 4'b1111);
    assign hlt_skid = (skid_q[15:14] == 2'b11) && (skid_q[7:4] == 4'b1111);
    // Once halted, only reset can restart fetch, so redirects are dropped.
    assign br_take  = BR_TAKEN && (state_q != HALT);
    assign HALTED   = halted_q;
`else
    assign br_take  = BR_TAKEN;
    assign HALTED   = 1'b0;
`endif

    assign IMEM_REQ   = (state_q == REQ);
    assign IMEM_ADDR  = pc_q;
    assign EXEC       = exec_q;
    assign EXEC_VALID = exec_vld_q;
    assign PC_OUT     = pc_out_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            exec_q     <= '0;
            exec_vld_q <= 1'b0;
            pc_out_q   <= RESET_PC;
            skid_q     <= '0;
            skid_pc_q  <= RESET_PC;
`ifdef IF_HALT_DETECT_EN
            halted_q   <= 1'b0;
`endif
        end else if (br_take) begin
            // Redirect wins over ACK, stall and any pending skid word.
            pc_q       <= BR_TARGET;
            exec_vld_q <= 1'b0;
            state_q    <= REQ;
        end else begin
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: begin
                    if (IMEM_ACK) begin
                        pc_q <= pc_q + PC_ONE;
                        if (slot_free) begin
                            exec_q     <= IMEM_RDATA;
                            pc_out_q   <= pc_q;
                            exec_vld_q <= 1'b1;
`ifdef IF_HALT_DETECT_EN
                            if (hlt_mem) begin
                                state_q  <= HALT;
                                halted_q <= 1'b1;
                            end
`endif
                        end else begin
                            skid_q    <= IMEM_RDATA;
                            skid_pc_q <= pc_q;
                            state_q   <= HOLD;
                        end
                    end else if (consumed) begin
                        exec_vld_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!STALL) begin
                        exec_q     <= skid_q;
                        pc_out_q   <= skid_pc_q;
                        exec_vld_q <= 1'b1;
                        state_q    <= REQ;
`ifdef IF_HALT_DETECT_EN
                        if (hlt_skid) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end
`endif
                    end
                end
`ifdef IF_HALT_DETECT_EN
                HALT: begin
                    if (consumed) begin
                        exec_vld_q <= 1'b0;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: cycle vector table plus a fetch/consume scoreboard.
module tb_instruction_fetch;

    logic        CLOCK;
    logic        RESET;
    logic        IMEM_REQ;
    logic [15:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [15:0] IMEM_RDATA;
    logic        STALL;
    logic        BR_TAKEN;
    logic [15:0] BR_TARGET;
    logic [15:0] EXEC;
    logic        EXEC_VALID;
    logic [15:0] PC_OUT;
    logic        HALTED;

    logic ack_en;
    logic halt_mode;

    instruction_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .IMEM_REQ  (IMEM_REQ),
        .IMEM_ADDR (IMEM_ADDR),
        .IMEM_ACK  (IMEM_ACK),
        .IMEM_RDATA(IMEM_RDATA),
        .STALL     (STALL),
        .BR_TAKEN  (BR_TAKEN),
        .BR_TARGET (BR_TARGET),
        .EXEC      (EXEC),
        .EXEC_VALID(EXEC_VALID),
        .PC_OUT    (PC_OUT),
        .HALTED    (HALTED)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Memory model: data is address + 0x1000, except a HLT word at address 3 in halt mode.
    assign IMEM_ACK   = ack_en;
    assign IMEM_RDATA = (halt_mode && IMEM_ADDR == 16'h0003) ? 16'hC0F0 : IMEM_ADDR + 16'h1000;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;
    txn_t sb_q[$];

    typedef struct {
        logic        st;
        logic        ak;
        logic        br;
        logic [15:0] tgt;
        logic [50:0] exp;
        logic        dc;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string nm, input logic [50:0] act, input logic [50:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Packed as {req, addr, valid, exec, pc_out, halted}; dc masks exec/pc_out.
    task automatic cmp_outs(input string nm, input logic [50:0] exp, input logic dc);
        logic [50:0] act;
        logic [50:0] e;
        act = {IMEM_REQ, IMEM_ADDR, EXEC_VALID, EXEC, PC_OUT, HALTED};
        e   = exp;
        if (dc) begin
            act[32:1] = '0;
            e[32:1]   = '0;
        end
        check(nm, act, e);
    endtask

    task automatic step(input string nm, input logic [50:0] exp, input logic dc);
        @(negedge CLOCK);
        cmp_outs(nm, exp, dc);
        @(posedge CLOCK);
        #1;
    endtask

    task automatic row(input logic st, input logic ak, input logic br, input logic [15:0] tgt,
                       input logic rq, input logic [15:0] ad, input logic vl,
                       input logic [15:0] ex, input logic [15:0] pc, input logic dc);
        vec_t v;
        v.st  = st;
        v.ak  = ak;
        v.br  = br;
        v.tgt = tgt;
        v.exp = {rq, ad, vl, ex, pc, 1'b0};
        v.dc  = dc;
        vecs.push_back(v);
    endtask

    // Scoreboard: every accepted fetch is pushed; every consumed EXEC must match the oldest one.
    always @(negedge CLOCK) begin
        txn_t t;
        if (RESET) begin
            sb_q.delete();
        end else begin
            if (EXEC_VALID && !STALL) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow actual_exec=%h actual_pc=%h required=none", EXEC, PC_OUT);
                end else begin
                    t = sb_q.pop_front();
                    check("sb_word", {19'b0, EXEC, PC_OUT}, {19'b0, t.data, t.addr});
                end
            end
            if (BR_TAKEN && !HALTED) begin
                sb_q.delete();
            end else if (IMEM_REQ && IMEM_ACK) begin
                sb_q.push_back('{IMEM_ADDR, IMEM_RDATA});
            end
        end
    end

    initial begin
        RESET = 1'b1; STALL = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = '0;
        ack_en = 1'b1; halt_mode = 1'b0;

        // st ak br tgt       req addr  vld exec      pc_out    dc
        row(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        row(0, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        row(0, 1, 0, 16'h0000, 1, 16'h0001, 1, 16'h1000, 16'h0000, 0);
        row(0, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'h1001, 16'h0001, 0);
        row(1, 1, 0, 16'h0000, 1, 16'h0003, 1, 16'h1002, 16'h0002, 0);
        row(1, 1, 0, 16'h0000, 0, 16'h0004, 1, 16'h1002, 16'h0002, 0);
        row(1, 1, 0, 16'h0000, 0, 16'h0004, 1, 16'h1002, 16'h0002, 0);
        row(0, 1, 0, 16'h0000, 0, 16'h0004, 1, 16'h1002, 16'h0002, 0);
        row(0, 1, 0, 16'h0000, 1, 16'h0004, 1, 16'h1003, 16'h0003, 0);
        row(0, 1, 0, 16'h0000, 1, 16'h0005, 1, 16'h1004, 16'h0004, 0);
        row(1, 1, 0, 16'h0000, 1, 16'h0006, 1, 16'h1005, 16'h0005, 0);
        row(1, 1, 1, 16'h0040, 0, 16'h0007, 1, 16'h1005, 16'h0005, 0);
        row(0, 1, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000, 1);
        row(0, 0, 0, 16'h0000, 1, 16'h0041, 1, 16'h1040, 16'h0040, 0);
        row(0, 0, 0, 16'h0000, 1, 16'h0041, 0, 16'h1040, 16'h0040, 0);
        row(0, 0, 0, 16'h0000, 1, 16'h0041, 0, 16'h1040, 16'h0040, 0);
        row(0, 0, 0, 16'h0000, 1, 16'h0041, 0, 16'h1040, 16'h0040, 0);
        row(0, 1, 0, 16'h0000, 1, 16'h0041, 0, 16'h1040, 16'h0040, 0);
        row(0, 1, 1, 16'hFFFF, 1, 16'h0042, 1, 16'h1041, 16'h0041, 0);
        row(0, 1, 0, 16'h0000, 1, 16'hFFFF, 0, 16'h0000, 16'h0000, 1);
        row(0, 1, 0, 16'h0000, 1, 16'h0000, 1, 16'h0FFF, 16'hFFFF, 0);
        row(0, 0, 0, 16'h0000, 1, 16'h0001, 1, 16'h1000, 16'h0000, 0);
        row(0, 0, 0, 16'h0000, 1, 16'h0001, 0, 16'h1000, 16'h0000, 0);

        @(negedge CLOCK);
        cmp_outs("reset_values", 51'b0, 1'b0);
        @(posedge CLOCK);
        #1 RESET = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            STALL     = vecs[i].st;
            ack_en    = vecs[i].ak;
            BR_TAKEN  = vecs[i].br;
            BR_TARGET = vecs[i].tgt;
            step($sformatf("row%0d", i), vecs[i].exp, vecs[i].dc);
        end
        STALL = 1'b0; ack_en = 1'b0; BR_TAKEN = 1'b0;

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain actual_pending=%0d required=0", sb_q.size());
        end

        // Asynchronous reset in the middle of a pending request.
        ack_en = 1'b1;
        RESET  = 1'b1;
        #1;
        cmp_outs("async_reset", 51'b0, 1'b0);
        halt_mode = 1'b1;
        @(posedge CLOCK);
        #1 RESET = 1'b0;

        step("halt_idle", {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0}, 1'b0);
        step("halt_req0", {1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0}, 1'b0);
        step("halt_req1", {1'b1, 16'h0001, 1'b1, 16'h1000, 16'h0000, 1'b0}, 1'b0);
        step("halt_req2", {1'b1, 16'h0002, 1'b1, 16'h1001, 16'h0001, 1'b0}, 1'b0);
        step("halt_req3", {1'b1, 16'h0003, 1'b1, 16'h1002, 16'h0002, 1'b0}, 1'b0);
`ifdef IF_HALT_DETECT_EN
        step("halt_load", {1'b0, 16'h0004, 1'b1, 16'hC0F0, 16'h0003, 1'b1}, 1'b0);
        BR_TAKEN = 1'b1; BR_TARGET = 16'h0080;
        step("halt_br",   {1'b0, 16'h0004, 1'b0, 16'hC0F0, 16'h0003, 1'b1}, 1'b0);
        BR_TAKEN = 1'b0;
        step("halt_stay", {1'b0, 16'h0004, 1'b0, 16'hC0F0, 16'h0003, 1'b1}, 1'b0);
`else
        step("hlt_pass",  {1'b1, 16'h0004, 1'b1, 16'hC0F0, 16'h0003, 1'b0}, 1'b0);
        BR_TAKEN = 1'b1; BR_TARGET = 16'h0080;
        step("hlt_br",    {1'b1, 16'h0005, 1'b1, 16'h1004, 16'h0004, 1'b0}, 1'b0);
        BR_TAKEN = 1'b0;
        step("hlt_redir", {1'b1, 16'h0080, 1'b0, 16'h0000, 16'h0000, 1'b0}, 1'b1);
`endif

        RESET = 1'b1;
        @(posedge CLOCK);
        #1 RESET = 1'b0;
        step("restart_idle", {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0}, 1'b0);
        step("restart_req",  {1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
